// File: rtl/sram_fifo_pkg.sv
// Shared defaults and types for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic {
        GNT_PUSH = 1'b0,
        GNT_POP  = 1'b1
    } grant_e;

endpackage

// File: rtl/sram_fifo_arb2.sv
// Two-requester round-robin arbiter for the single SRAM port (push vs pop).
module sram_fifo_arb2
    import sram_fifo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_push,
    input  logic req_pop,
    output logic grant_push,
    output logic grant_pop
);

    grant_e last_grant_q, last_grant_d;

    always_comb begin
        grant_push   = 1'b0;
        grant_pop    = 1'b0;
        last_grant_d = last_grant_q;
        if (req_push && req_pop) begin
            // Contention: hand the port to whoever did not win last time.
            if (last_grant_q == GNT_POP) begin
                grant_push = 1'b1;
            end else begin
                grant_pop = 1'b1;
            end
        end else begin
            grant_push = req_push;
            grant_pop  = req_pop;
        end
        if (grant_push) begin
            last_grant_d = GNT_PUSH;
        end else if (grant_pop) begin
            last_grant_d = GNT_POP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GNT_POP;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving a single-port SRAM (combinational read, registered write).
// Optional sticky overflow/underflow flags enabled by defining SRAM_FIFO_CTRL_ERR_EN.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ack,
    input  logic              pop_req,
    output logic              pop_ack,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_dvalid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              err_ovf,
    output logic              err_udf
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_dvalid_q, pop_dvalid_d;

    logic push_elig, pop_elig;
    logic grant_push, grant_pop;

    // Flags come from occupancy, so a full and an empty FIFO never alias.
    assign full      = (count_q == DEPTH);
    assign empty     = (count_q == '0);
    assign push_elig = push_req & ~full;
    assign pop_elig  = pop_req & ~empty;

    sram_fifo_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_push   (push_elig),
        .req_pop    (pop_elig),
        .grant_push (grant_push),
        .grant_pop  (grant_pop)
    );

    assign push_ack   = grant_push;
    assign pop_ack    = grant_pop;
    assign count      = count_q;
    assign pop_data   = pop_data_q;
    assign pop_dvalid = pop_dvalid_q;

    always_comb begin
        sram_wdata = push_data;
        sram_we    = grant_push;
        sram_addr  = grant_push ? wptr_q : rptr_q;
    end

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        pop_data_d   = pop_data_q;
        pop_dvalid_d = 1'b0;
        if (grant_push) begin
            wptr_d  = wptr_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
        end else if (grant_pop) begin
            rptr_d       = rptr_q + PTR_ONE;
            count_d      = count_q - CNT_ONE;
            pop_data_d   = sram_rdata;
            pop_dvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            pop_data_q   <= '0;
            pop_dvalid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            pop_data_q   <= pop_data_d;
            pop_dvalid_q <= pop_dvalid_d;
        end
    end

`ifdef SRAM_FIFO_CTRL_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    always_comb begin
        err_ovf_d = err_ovf_q | (push_req & full);
        err_udf_d = err_udf_q | (pop_req & empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed self-checking bench for sram_fifo_ctrl with a behavioural 16x8 SRAM.
module tb_sram_fifo_ctrl;

`ifdef SRAM_FIFO_CTRL_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk, reset;
    logic       push_req, pop_req;
    logic [7:0] push_data, pop_data, sram_wdata, sram_rdata;
    logic       push_ack, pop_ack, pop_dvalid, full, empty, err_ovf, err_udf, sram_we;
    logic [4:0] count;
    logic [3:0] sram_addr;
    logic [7:0] mem [16];

    int vectors = 0;
    int miscompares = 0;

    sram_fifo_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_req   (push_req),
        .push_data  (push_data),
        .push_ack   (push_ack),
        .pop_req    (pop_req),
        .pop_ack    (pop_ack),
        .pop_data   (pop_data),
        .pop_dvalid (pop_dvalid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_rdata (sram_rdata),
        .err_ovf    (err_ovf),
        .err_udf    (err_udf)
    );

    // SRAM: combinational read, registered write.
    assign sram_rdata = mem[sram_addr];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic pu, input logic [7:0] d, input logic po);
        @(negedge clk);
        push_req  = pu;
        push_data = d;
        pop_req   = po;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count); end
        vectors++; if ({empty, full} !== 2'b10) begin miscompares++; $display("FAIL rst_flags: got %b want 10", {empty, full}); end
        vectors++; if ({pop_dvalid, pop_data} !== 9'h000) begin miscompares++; $display("FAIL rst_pop: got %h want 000", {pop_dvalid, pop_data}); end
        vectors++; if ({err_ovf, err_udf} !== 2'b00) begin miscompares++; $display("FAIL rst_err: got %b want 00", {err_ovf, err_udf}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b0);
            vectors++; if ({push_ack, sram_we, sram_addr} !== {2'b11, 4'(i + 3)} && {push_ack, sram_we, sram_addr} !== {2'b11, 4'(i)}) begin miscompares++; $display("FAIL basic_push%0d: got %h want ack/we high", i, {push_ack, sram_we, sram_addr}); end
            tick();
        end
        vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL basic_count3: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            vectors++; if ({pop_ack, push_ack} !== 2'b10) begin miscompares++; $display("FAIL basic_popack%0d: got %b want 10", i, {pop_ack, push_ack}); end
            tick();
            vectors++; if ({pop_dvalid, pop_data} !== {1'b1, vals[i]}) begin miscompares++; $display("FAIL basic_pop%0d: got %h want %h", i, {pop_dvalid, pop_data}, {1'b1, vals[i]}); end
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        vectors++; if ({pop_dvalid, empty, count} !== {2'b01, 5'd0}) begin miscompares++; $display("FAIL basic_end: got %b want 0100000", {pop_dvalid, empty, count}); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
        end
        vectors++; if ({full, empty, count} !== {2'b10, 5'd16}) begin miscompares++; $display("FAIL full_state: got %b want 1010000", {full, empty, count}); end
        drive(1'b1, 8'hAA, 1'b0);
        vectors++; if (push_ack !== 1'b0) begin miscompares++; $display("FAIL full_noack: got %b want 0", push_ack); end
        tick();
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL full_hold: got %0d want 16", count); end
        vectors++; if (err_ovf !== ERR_EN) begin miscompares++; $display("FAIL full_ovf: got %b want %b", err_ovf, ERR_EN); end
        // Both requests while full: the pop must win.
        drive(1'b1, 8'hAA, 1'b1);
        vectors++; if ({push_ack, pop_ack} !== 2'b01) begin miscompares++; $display("FAIL full_both: got %b want 01", {push_ack, pop_ack}); end
        tick();
        vectors++; if ({pop_dvalid, pop_data} !== 9'h100) begin miscompares++; $display("FAIL full_pop0: got %h want 100", {pop_dvalid, pop_data}); end
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
            vectors++; if ({pop_dvalid, pop_data} !== {1'b1, 8'(i)}) begin miscompares++; $display("FAIL full_pop%0d: got %h want %h", i, {pop_dvalid, pop_data}, {1'b1, 8'(i)}); end
        end
        vectors++; if ({empty, count} !== 6'b100000) begin miscompares++; $display("FAIL full_drained: got %b want 100000", {empty, count}); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b1);
            vectors++; if (count > 5'd1) begin miscompares++; $display("FAIL b2b_count%0d: got %0d want <=1", i, count); end
            vectors++; if ({push_ack, pop_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL b2b_grant%0d: got %b want %b", i, {push_ack, pop_ack}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            tick();
            if (i % 2 == 1) begin
                vectors++; if ({pop_dvalid, pop_data} !== {1'b1, 8'(8'h40 + i - 1)}) begin miscompares++; $display("FAIL b2b_data%0d: got %h want %h", i, {pop_dvalid, pop_data}, {1'b1, 8'(8'h40 + i - 1)}); end
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL b2b_end: got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        int nums [2];
        logic [7:0] base [2];
        nums[0] = 12; nums[1] = 8; base[0] = 8'h80; base[1] = 8'hC0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < nums[r]; i++) begin
                drive(1'b1, base[r] + 8'(i), 1'b0);
                tick();
            end
            vectors++; if (count !== 5'(nums[r])) begin miscompares++; $display("FAIL wrap_cnt%0d: got %0d want %0d", r, count, nums[r]); end
            for (int i = 0; i < nums[r]; i++) begin
                drive(1'b0, 8'h00, 1'b1);
                tick();
                vectors++; if ({pop_dvalid, pop_data} !== {1'b1, base[r] + 8'(i)}) begin miscompares++; $display("FAIL wrap_pop%0d_%0d: got %h want %h", r, i, {pop_dvalid, pop_data}, {1'b1, base[r] + 8'(i)}); end
            end
        end
        vectors++; if ({empty, count} !== 6'b100000) begin miscompares++; $display("FAIL wrap_end: got %b want 100000", {empty, count}); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 8'h00, 1'b1);
        vectors++; if (pop_ack !== 1'b0) begin miscompares++; $display("FAIL udf_noack: got %b want 0", pop_ack); end
        tick();
        vectors++; if ({pop_dvalid, pop_data, count} !== {1'b0, 8'hC7, 5'd0}) begin miscompares++; $display("FAIL udf_hold: got %h want %h", {pop_dvalid, pop_data, count}, {1'b0, 8'hC7, 5'd0}); end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        vectors++; if (err_udf !== ERR_EN) begin miscompares++; $display("FAIL udf_sticky: got %b want %b", err_udf, ERR_EN); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        vectors++; if ({pop_ack, count} !== {1'b1, 5'd5}) begin miscompares++; $display("FAIL rmid_pre: got %b want 100101", {pop_ack, count}); end
        #1 reset = 1'b1;
        #1;
        vectors++; if ({count, empty, pop_dvalid, pop_data} !== {5'd0, 2'b10, 8'h00}) begin miscompares++; $display("FAIL rmid_clear: got %h want %h", {count, empty, pop_dvalid, pop_data}, {5'd0, 2'b10, 8'h00}); end
        vectors++; if ({err_ovf, err_udf} !== 2'b00) begin miscompares++; $display("FAIL rmid_err: got %b want 00", {err_ovf, err_udf}); end
        tick();
        vectors++; if (pop_dvalid !== 1'b0) begin miscompares++; $display("FAIL rmid_dvalid: got %b want 0", pop_dvalid); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        vectors++; if (pop_ack !== 1'b0) begin miscompares++; $display("FAIL rmid_stale: got %b want 0", pop_ack); end
        drive(1'b1, 8'h99, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        vectors++; if ({pop_dvalid, pop_data, count} !== {1'b1, 8'h99, 5'd0}) begin miscompares++; $display("FAIL rmid_new: got %h want %h", {pop_dvalid, pop_data, count}, {1'b1, 8'h99, 5'd0}); end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        push_data = 8'h00;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_wrap();
        test_underflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
